// File: rtl/dds_nco_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_nco_if
// Description : Frequency-word update handshake between the frequency
//               selector (master) and the NCO (slave).
//                 fre_k   : requested frequency control word
//                 fre_ld  : one-cycle strobe, capture fre_k as pending word
//                 fre_ack : one-cycle pulse, pending word became active
//                 step    : currently active frequency word
// Revision    : 1.0  initial release
// ============================================================================
interface dds_nco_if #(
  parameter int PHASE_W = 32
);
  logic [PHASE_W-1:0] fre_k;
  logic               fre_ld;
  logic               fre_ack;
  logic [PHASE_W-1:0] step;

  modport master (output fre_k, output fre_ld, input fre_ack, input step);
  modport slave  (input fre_k, input fre_ld, output fre_ack, output step);
endinterface
`default_nettype wire

// File: rtl/dds_nco.sv
`default_nettype none
// ============================================================================
// Module      : dds_nco
// Description : Numerically controlled oscillator. Phase accumulator with a
//               frequency-word update that only takes effect at phase wrap
//               (or immediately while the active step is zero), followed by a
//               3-stage quarter-wave sine/cosine lookup.
// Ports       : clk, rst        clock, synchronous active-high reset
//               i_en            accumulator advance enable
//               fre_if          frequency update handshake (slave side)
//               o_phase         accumulator value
//               o_wrap          pulse after an add that carried out
//               o_sin_out       signed sine sample
//               o_cos_out       signed cosine sample
//               o_out_valid     samples belong to an enabled accumulator cycle
// Revision    : 1.0  initial release
// ============================================================================
module dds_nco #(
  parameter int                 PHASE_W  = 32,
  parameter int                 LUT_AW   = 10,
  parameter int                 OUT_W    = 12,
  parameter logic [PHASE_W-1:0] FRE_INIT = 34360
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    i_en,
  dds_nco_if.slave                     fre_if,
  output logic        [PHASE_W-1:0]    o_phase,
  output logic                         o_wrap,
  output logic signed [OUT_W-1:0]      o_sin_out,
  output logic signed [OUT_W-1:0]      o_cos_out,
  output logic                         o_out_valid
);

  localparam int c_QW  = LUT_AW - 2;              // quarter-table address width
  localparam int c_QN  = 1 << c_QW;               // quarter-table entries
  localparam int c_AMP = (1 << (OUT_W - 1)) - 1;  // symmetric full scale
  localparam real c_PI = 3.14159265358979323846;

  // --------------------------------------------------------------------------
  // Phase accumulator and frequency-word update
  // --------------------------------------------------------------------------
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_step;
  logic [PHASE_W-1:0] r_pend;
  logic               r_pend_v;
  logic               r_wrap;
  logic               r_ack;

  logic [PHASE_W:0]   w_sum;
  logic               w_carry;
  logic               w_apply;

  assign w_sum   = {1'b0, r_phase} + {1'b0, r_step};
  assign w_carry = i_en & w_sum[PHASE_W];
  // A zero step never wraps, so it is replaced without waiting for a carry.
  assign w_apply = r_pend_v & (w_carry | (r_step == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= '0;
      r_step   <= FRE_INIT;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_wrap   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_wrap <= w_carry;
      r_ack  <= w_apply;
      if (i_en) begin
        r_phase <= w_sum[PHASE_W-1:0];   // carry cycle still uses the old step
      end
      if (w_apply) begin
        r_step   <= r_pend;
        r_pend_v <= 1'b0;
      end
      // Placed after the apply so a strobe in the apply cycle re-arms pending.
      if (fre_if.fre_ld) begin
        r_pend   <= fre_if.fre_k;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign o_phase        = r_phase;
  assign o_wrap         = r_wrap;
  assign fre_if.step    = r_step;
  assign fre_if.fre_ack = r_ack;

  // --------------------------------------------------------------------------
  // Quarter-wave table, sampled at half-step offsets so the quadrant mirror
  // is exact and zero is never an entry: T[k] = round(A*sin(2pi(k+0.5)/N)).
  // --------------------------------------------------------------------------
  logic [OUT_W-2:0] w_tab [c_QN];

  generate
    for (genvar k = 0; k < c_QN; k++) begin : g_tab
      localparam real c_ANG = 2.0 * c_PI * (k + 0.5) / (4.0 * c_QN);
      assign w_tab[k] = (OUT_W-1)'($rtoi(c_AMP * $sin(c_ANG) + 0.5));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // S1: table index for sine, cosine is a quarter turn ahead
  // --------------------------------------------------------------------------
  logic [LUT_AW-1:0] w_idx_s;
  logic [LUT_AW-1:0] w_idx_c;
  logic [LUT_AW-1:0] r_s1_idx_s;
  logic [LUT_AW-1:0] r_s1_idx_c;

  assign w_idx_s = r_phase[PHASE_W-1 -: LUT_AW];
  assign w_idx_c = w_idx_s + LUT_AW'(c_QN);

  // S2: mirror address in odd quadrants, remember sign for the lower half
  logic [c_QW-1:0]  w_adr_s;
  logic [c_QW-1:0]  w_adr_c;
  logic [OUT_W-2:0] r_s2_mag_s;
  logic [OUT_W-2:0] r_s2_mag_c;
  logic             r_s2_neg_s;
  logic             r_s2_neg_c;

  assign w_adr_s = r_s1_idx_s[c_QW] ? ~r_s1_idx_s[c_QW-1:0] : r_s1_idx_s[c_QW-1:0];
  assign w_adr_c = r_s1_idx_c[c_QW] ? ~r_s1_idx_c[c_QW-1:0] : r_s1_idx_c[c_QW-1:0];

  // S3: apply sign
  logic [OUT_W-1:0] w_ext_s;
  logic [OUT_W-1:0] w_ext_c;
  logic [OUT_W-1:0] r_sin;
  logic [OUT_W-1:0] r_cos;
  logic [2:0]       r_vld;

  assign w_ext_s = {1'b0, r_s2_mag_s};
  assign w_ext_c = {1'b0, r_s2_mag_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_idx_s <= '0;
      r_s1_idx_c <= '0;
      r_s2_mag_s <= '0;
      r_s2_mag_c <= '0;
      r_s2_neg_s <= 1'b0;
      r_s2_neg_c <= 1'b0;
      r_sin      <= '0;
      r_cos      <= '0;
      r_vld      <= '0;
    end else begin
      r_s1_idx_s <= w_idx_s;
      r_s1_idx_c <= w_idx_c;
      r_s2_mag_s <= w_tab[w_adr_s];
      r_s2_mag_c <= w_tab[w_adr_c];
      r_s2_neg_s <= r_s1_idx_s[LUT_AW-1];
      r_s2_neg_c <= r_s1_idx_c[LUT_AW-1];
      r_sin      <= r_s2_neg_s ? -w_ext_s : w_ext_s;
      r_cos      <= r_s2_neg_c ? -w_ext_c : w_ext_c;
      r_vld      <= {r_vld[1:0], i_en};
    end
  end

  assign o_sin_out   = r_sin;
  assign o_cos_out   = r_cos;
  assign o_out_valid = r_vld[2];

endmodule
`default_nettype wire

// File: tb/tb_dds_nco.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_nco
// Description : Self-checking bench. Instance A uses default parameters for
//               reset / start-up behaviour; instance B starts with a zero
//               step so frequency words load immediately and wraps come
//               quickly, and runs a table of per-cycle vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dds_nco;

  localparam logic [31:0] c_Q = 32'h4000_0000;
  localparam logic [31:0] c_H = 32'h8000_0000;
  localparam logic [31:0] c_T = 32'hC000_0000;
  localparam logic [31:0] c_E = 32'h2000_0000;
  localparam int          c_N = 40;

  logic clk = 1'b0;
  logic rst;
  logic a_en, b_en;

  logic [31:0]        a_phase, b_phase;
  logic               a_wrap, b_wrap;
  logic signed [11:0] a_sin, a_cos, b_sin, b_cos;
  logic               a_vld, b_vld;

  dds_nco_if #(.PHASE_W(32)) a_if ();
  dds_nco_if #(.PHASE_W(32)) b_if ();

  dds_nco u_a (
    .clk(clk), .rst(rst), .i_en(a_en), .fre_if(a_if),
    .o_phase(a_phase), .o_wrap(a_wrap), .o_sin_out(a_sin),
    .o_cos_out(a_cos), .o_out_valid(a_vld)
  );

  dds_nco #(.FRE_INIT(32'd0)) u_b (
    .clk(clk), .rst(rst), .i_en(b_en), .fre_if(b_if),
    .o_phase(b_phase), .o_wrap(b_wrap), .o_sin_out(b_sin),
    .o_cos_out(b_cos), .o_out_valid(b_vld)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [31:0] k;
    logic [31:0] step;
    logic [31:0] phase;
    logic        wrap;
    logic        ack;
  } vec_t;

  vec_t tbl [c_N];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected samples at the four quadrant boundaries of the phase circle.
  function automatic bit lut_exp(input logic [31:0] ph, output int s, output int c);
    s = 0; c = 0;
    if (ph == 32'd0) begin s = 6;     c = 2047;  return 1'b1; end
    if (ph == c_Q)   begin s = 2047;  c = -6;    return 1'b1; end
    if (ph == c_H)   begin s = -6;    c = -2047; return 1'b1; end
    if (ph == c_T)   begin s = -2047; c = 6;     return 1'b1; end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int es, ec;
    //            en  ld  k     | step  phase    wrap ack
    tbl[0]  = '{1'b1, 1'b1, c_Q,   32'd0, 32'd0,   1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'd0, c_Q,   32'd0,   1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'd0, c_Q,   c_Q,     1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, c_H,   c_Q,   c_H,     1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'd0, c_Q,   c_T,     1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd0, c_H,   32'd0,   1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'd0, c_H,   32'd0,   1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, c_E,   c_H,   c_H,     1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, c_Q,   c_H,   c_H,     1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'd0, c_Q,   32'd0,   1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'd0, c_Q,   c_Q,     1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'd0, c_Q,   c_H,     1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, c_E,   c_Q,   c_T,     1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, c_H,   c_E,   32'd0,   1'b1, 1'b1};
    for (int i = 16; i < 23; i++)
      tbl[i] = '{1'b1, 1'b0, 32'd0, c_E, c_E * (i - 15), 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 32'd0, c_H,   32'd0,   1'b1, 1'b1};
    tbl[24] = '{1'b1, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, c_Q,   c_H,   32'd0,   1'b1, 1'b0};
    tbl[26] = '{1'b1, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[27] = '{1'b1, 1'b0, 32'd0, c_Q,   32'd0,   1'b1, 1'b1};
    tbl[28] = '{1'b1, 1'b1, 32'd0, c_Q,   c_Q,     1'b0, 1'b0};
    tbl[29] = '{1'b1, 1'b0, 32'd0, c_Q,   c_H,     1'b0, 1'b0};
    tbl[30] = '{1'b1, 1'b0, 32'd0, c_Q,   c_T,     1'b0, 1'b0};
    tbl[31] = '{1'b1, 1'b0, 32'd0, 32'd0, 32'd0,   1'b1, 1'b1};
    tbl[32] = '{1'b1, 1'b0, 32'd0, 32'd0, 32'd0,   1'b0, 1'b0};
    tbl[33] = '{1'b1, 1'b0, 32'd0, 32'd0, 32'd0,   1'b0, 1'b0};
    tbl[34] = '{1'b0, 1'b1, c_H,   32'd0, 32'd0,   1'b0, 1'b0};
    tbl[35] = '{1'b0, 1'b0, 32'd0, c_H,   32'd0,   1'b0, 1'b1};
    tbl[36] = '{1'b1, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[37] = '{1'b1, 1'b0, 32'd0, c_H,   32'd0,   1'b1, 1'b0};
    tbl[38] = '{1'b1, 1'b0, 32'd0, c_H,   c_H,     1'b0, 1'b0};
    tbl[39] = '{1'b1, 1'b0, 32'd0, c_H,   32'd0,   1'b1, 1'b0};

    rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
    a_if.fre_ld = 1'b0; a_if.fre_k = '0;
    b_if.fre_ld = 1'b0; b_if.fre_k = '0;
    tick(); tick();

    // Reset state
    chk("rst a_phase", a_phase, 32'd0);
    chk("rst a_step", a_if.step, 32'd34360);
    chk("rst a_wrap", {31'd0, a_wrap}, 32'd0);
    chk("rst a_ack", {31'd0, a_if.fre_ack}, 32'd0);
    chk("rst a_sin", 32'(a_sin), 32'd0);
    chk("rst a_cos", 32'(a_cos), 32'd0);
    chk("rst a_vld", {31'd0, a_vld}, 32'd0);
    chk("rst b_step", b_if.step, 32'd0);
    rst = 1'b0;

    // Start-up at the default frequency word
    for (int r = 0; r < 10; r++) begin
      a_en = 1'b1;
      tick();
      chk($sformatf("start vld c%0d", r), {31'd0, a_vld}, {31'd0, r >= 2});
      chk($sformatf("start wrap c%0d", r), {31'd0, a_wrap}, 32'd0);
    end
    chk("start phase", a_phase, 32'd343600);
    chk("start step", a_if.step, 32'd34360);
    chk("start sin", 32'(a_sin), 32'd6);
    chk("start cos", 32'(a_cos), 32'd2047);

    // Reset while a word is pending; B would otherwise apply at this edge
    a_if.fre_ld = 1'b1; a_if.fre_k = 32'd343600;
    b_if.fre_ld = 1'b1; b_if.fre_k = c_H;
    tick();
    a_if.fre_ld = 1'b0; b_if.fre_ld = 1'b0; a_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst a_phase", a_phase, 32'd0);
    chk("mrst a_step", a_if.step, 32'd34360);
    chk("mrst a_ack", {31'd0, a_if.fre_ack}, 32'd0);
    chk("mrst a_sin", 32'(a_sin), 32'd0);
    chk("mrst a_cos", 32'(a_cos), 32'd0);
    chk("mrst a_vld", {31'd0, a_vld}, 32'd0);
    chk("mrst b_step", b_if.step, 32'd0);
    for (int r = 0; r < 5; r++) begin
      tick();
      chk($sformatf("mrst a_ack c%0d", r), {31'd0, a_if.fre_ack}, 32'd0);
      chk($sformatf("mrst b_ack c%0d", r), {31'd0, b_if.fre_ack}, 32'd0);
      chk($sformatf("mrst b_step c%0d", r), b_if.step, 32'd0);
    end

    // Per-cycle handshake / accumulator / LUT vectors on B
    for (int r = 0; r < c_N; r++) begin
      b_en = tbl[r].en;
      b_if.fre_ld = tbl[r].ld;
      b_if.fre_k = tbl[r].k;
      tick();
      chk($sformatf("v%0d step", r), b_if.step, tbl[r].step);
      chk($sformatf("v%0d phase", r), b_phase, tbl[r].phase);
      chk($sformatf("v%0d wrap", r), {31'd0, b_wrap}, {31'd0, tbl[r].wrap});
      chk($sformatf("v%0d ack", r), {31'd0, b_if.fre_ack}, {31'd0, tbl[r].ack});
      if (r >= 2)
        chk($sformatf("v%0d vld", r), {31'd0, b_vld}, {31'd0, tbl[r-2].en});
      if (r >= 3) begin
        if (lut_exp(tbl[r-3].phase, es, ec)) begin
          chk($sformatf("v%0d sin", r), 32'(b_sin), 32'(es));
          chk($sformatf("v%0d cos", r), 32'(b_cos), 32'(ec));
        end
      end
    end
    b_en = 1'b0; b_if.fre_ld = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
